// File: rtl/spi_pkg.sv
// spi_pkg: shared types and defaults for the SPI receive path.
// Imported by spi_rx, spi_sync and spi_rx_if.
package spi_pkg;

    typedef enum logic {
        SPI_RX_IDLE,
        SPI_RX_SHIFT
    } spi_rx_state_e;

    localparam int SPI_DATA_W = 8;

endpackage

// File: rtl/spi_rx_if.sv
// spi_rx_if: received-word valid/ready port plus error pulses.
// master = spi_rx side, slave = command decoder side.
interface spi_rx_if
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
);

    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
    logic              overrun_o;
    logic              frame_err_o;

    modport master (
        output data_o,
        output valid_o,
        output overrun_o,
        output frame_err_o,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  valid_o,
        input  overrun_o,
        input  frame_err_o,
        output ready_i
    );

endinterface

// File: rtl/spi_sync.sv
// spi_sync: STAGES-deep flop synchronizer with a configurable reset value.
// Used once per asynchronous SPI pad input.
module spi_sync
    import spi_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d_i};
        end
    end

    assign q_o = ff[STAGES-1];

endmodule

// File: rtl/spi_rx.sv
// spi_rx: SPI mode-0 receiver, MSB first, single-entry output holding register.
// Optional partial-word idle timeout: define SPI_RX_TIMEOUT_EN.
module spi_rx
    import spi_pkg::*;
#(
    parameter int DATA_W         = SPI_DATA_W,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     sclk_i,
    input  logic     cs_n_i,
    input  logic     mosi_i,
    spi_rx_if.master rx
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    if (DATA_W < 2 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("spi_rx: DATA_W, SYNC_STAGES or TIMEOUT_CYCLES out of range");
    end

    logic sclk_s, cs_n_s, mosi_s, sclk_prev, rise;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(sclk_i), .q_o(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(cs_n_i), .q_o(cs_n_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(mosi_i), .q_o(mosi_s)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) sclk_prev <= 1'b0;
        else       sclk_prev <= sclk_s;
    end

    assign rise = sclk_s & ~sclk_prev;

    spi_rx_state_e    state_q, state_d;
    logic [CNT_W-1:0] bit_cnt;
    logic [DATA_W-1:0] shreg, word;
    logic start, shift_en, complete, abort, ferr_d, timeout;

    assign word = {shreg[DATA_W-2:0], mosi_s};

`ifdef SPI_RX_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle_cnt;
    logic          idle_run;

    assign idle_run = (state_q == SPI_RX_SHIFT) && !cs_n_s && !rise
                   && (bit_cnt != LAST);
    assign timeout  = idle_run && (idle_cnt == IW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || !idle_run || timeout) idle_cnt <= '0;
        else                               idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= SPI_RX_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SPI_RX_IDLE:  if (!cs_n_s) state_d = SPI_RX_SHIFT;
            SPI_RX_SHIFT: if (cs_n_s)  state_d = SPI_RX_IDLE;
        endcase
    end

    // completion outranks a simultaneous cs_n release
    always_comb begin
        start    = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        shift_en = 1'b0;
        ferr_d   = 1'b0;
        unique case (state_q)
            SPI_RX_IDLE: begin
                start = !cs_n_s;
            end
            SPI_RX_SHIFT: begin
                complete = rise && (bit_cnt == '0);
                abort    = cs_n_s && !complete;
                shift_en = rise && !abort;
                ferr_d   = (abort && (bit_cnt != LAST)) || timeout;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg   <= '0;
            bit_cnt <= LAST;
        end else if (start || abort || timeout) begin
            shreg   <= '0;
            bit_cnt <= LAST;
        end else if (shift_en) begin
            shreg   <= word;
            bit_cnt <= complete ? LAST : bit_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx.data_o      <= '0;
            rx.valid_o     <= 1'b0;
            rx.overrun_o   <= 1'b0;
            rx.frame_err_o <= 1'b0;
        end else begin
            rx.frame_err_o <= ferr_d;
            rx.overrun_o   <= complete && rx.valid_o && !rx.ready_i;
            if (complete && (!rx.valid_o || rx.ready_i)) begin
                rx.data_o  <= word;
                rx.valid_o <= 1'b1;
            end else if (rx.ready_i) begin
                rx.valid_o <= 1'b0;
            end
        end
    end

endmodule
